// File: rtl/segdisplay_mux_if.sv
// Host-side frame/brightness inputs and board-side seg/an pins of the multiplexed 7-segment driver.
// Purely combinational bundle; no backpressure, every signal is sampled or driven each cycle.
interface segdisplay_mux_if #(
  parameter int N_DIGITS = 4
);
  logic [4*N_DIGITS-1:0] digit_val;
  logic [N_DIGITS-1:0]   dp;
  logic [N_DIGITS-1:0]   blank;
  logic                  load;
  logic [3:0]            bright;
  logic [7:0]            seg;
  logic [N_DIGITS-1:0]   an;
  logic                  frame_done;

  modport master (
    output digit_val, dp, blank, load, bright,
    input  seg, an, frame_done
  );

  modport slave (
    input  digit_val, dp, blank, load, bright,
    output seg, an, frame_done
  );
endinterface

// File: rtl/segdisplay_mux.sv
// N-digit multiplexed 7-segment scanner with double-buffered frames and PWM brightness.
// Registered seg/an, one cycle after scan state; no backpressure, a load is accepted on any cycle.
module segdisplay_mux #(
  parameter int N_DIGITS   = 4,
  parameter int DWELL_LOG2 = 8
) (
  input  logic              segclk,
  input  logic              clr_n,
  segdisplay_mux_if.slave   bus
);
  localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [DWELL_LOG2-1:0] CNT_MAX = '1;
  localparam logic [DW-1:0]         DIG_TOP = DW'(N_DIGITS - 1);

  logic [DWELL_LOG2-1:0] cnt_q, cnt_d;
  logic [DW-1:0]         dig_q, dig_d;
  logic [4*N_DIGITS-1:0] act_val_q, act_val_d, pend_val_q, pend_val_d;
  logic [N_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic [N_DIGITS-1:0]   act_blank_q, act_blank_d, pend_blank_q, pend_blank_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [7:0]            seg_q, seg_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic                  frame_done_q, frame_done_d;

  logic                  boundary;
  logic [3:0]            cur_val;
  logic                  cur_dp;
  logic                  cur_blank;
  logic                  lit;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  // Scan: leftmost digit first, one slot of 2**DWELL_LOG2 cycles each.
  always_comb begin
    cnt_d    = cnt_q + 1'b1;
    dig_d    = dig_q;
    boundary = (cnt_q == CNT_MAX) && (dig_q == '0);
    if (cnt_q == CNT_MAX) begin
      dig_d = (dig_q == '0) ? DIG_TOP : dig_q - 1'b1;
    end
  end

  // The active buffer only moves at the frame boundary, so a frame never tears.
  always_comb begin
    act_val_d    = act_val_q;
    act_dp_d     = act_dp_q;
    act_blank_d  = act_blank_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    pend_vld_d   = pend_vld_q;
    frame_done_d = boundary;
    if (bus.load) begin
      pend_val_d   = bus.digit_val;
      pend_dp_d    = bus.dp;
      pend_blank_d = bus.blank;
      pend_vld_d   = 1'b1;
    end
    if (boundary) begin
      pend_vld_d = 1'b0;
      if (bus.load) begin
        act_val_d   = bus.digit_val;
        act_dp_d    = bus.dp;
        act_blank_d = bus.blank;
      end else if (pend_vld_q) begin
        act_val_d   = pend_val_q;
        act_dp_d    = pend_dp_q;
        act_blank_d = pend_blank_q;
      end
    end
  end

  always_comb begin
    cur_val   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (dig_q == DW'(k)) begin
        cur_val   = act_val_q[4*k +: 4];
        cur_dp    = act_dp_q[k];
        cur_blank = act_blank_q[k];
      end
    end
    // Top four count bits form the PWM phase within the slot.
    lit   = (cnt_q[DWELL_LOG2-1 -: 4] <= bus.bright) && !cur_blank;
    seg_d = lit ? {~cur_dp, hex7(cur_val)} : 8'hFF;
    an_d  = lit ? ~(N_DIGITS'(1) << dig_q) : '1;
  end

  always_ff @(posedge segclk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q        <= '0;
      dig_q        <= DIG_TOP;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '1;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '1;
      pend_vld_q   <= 1'b0;
      seg_q        <= 8'hFF;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      dig_q        <= dig_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      pend_vld_q   <= pend_vld_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_segdisplay_mux.sv
// Drives a 4-digit and an 8-digit scanner with shared stimulus and checks both against a time-based model.
module tb_segdisplay_mux;
  logic        segclk = 1'b0;
  logic        clr_n  = 1'b1;
  logic [31:0] st_val;
  logic [7:0]  st_dp, st_blank;
  logic        st_load;
  logic [3:0]  st_bright;

  always #5 segclk = ~segclk;

  segdisplay_mux_if #(.N_DIGITS(4)) if4 ();
  segdisplay_mux_if #(.N_DIGITS(8)) if8 ();

  assign if4.digit_val = st_val[15:0];
  assign if4.dp        = st_dp[3:0];
  assign if4.blank     = st_blank[3:0];
  assign if4.load      = st_load;
  assign if4.bright    = st_bright;
  assign if8.digit_val = st_val;
  assign if8.dp        = st_dp;
  assign if8.blank     = st_blank;
  assign if8.load      = st_load;
  assign if8.bright    = st_bright;

  segdisplay_mux #(.N_DIGITS(4), .DWELL_LOG2(4)) dut4 (.segclk(segclk), .clr_n(clr_n), .bus(if4));
  segdisplay_mux #(.N_DIGITS(8), .DWELL_LOG2(4)) dut8 (.segclk(segclk), .clr_n(clr_n), .bus(if8));

  logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int nd [2] = '{4, 8};

  // Model: scan position is pure arithmetic on the cycle count since reset release.
  int         t;
  logic [3:0] a_val [2][8];
  logic [3:0] p_val [2][8];
  logic       a_dp [2][8], p_dp [2][8], a_bl [2][8], p_bl [2][8];
  logic       pv [2];
  logic [7:0] e_seg [2], e_an [2];
  logic       e_fd [2];
  int         n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0d @%0t", tag, got, exp, t, $time);
    end
  endtask

  task automatic model_reset();
    t = 0;
    for (int i = 0; i < 2; i++) begin
      pv[i] = 1'b0;
      for (int k = 0; k < 8; k++) begin
        a_val[i][k] = 4'h0; a_dp[i][k] = 1'b0; a_bl[i][k] = 1'b1;
        p_val[i][k] = 4'h0; p_dp[i][k] = 1'b0; p_bl[i][k] = 1'b1;
      end
    end
  endtask

  task automatic model_step();
    int c, d;
    logic on, bnd;
    if (!clr_n) begin
      model_reset();
      for (int i = 0; i < 2; i++) begin
        e_seg[i] = 8'hFF; e_an[i] = 8'hFF; e_fd[i] = 1'b0;
      end
      return;
    end
    for (int i = 0; i < 2; i++) begin
      c   = t % 16;
      d   = nd[i] - 1 - (t / 16) % nd[i];
      on  = (c <= int'(st_bright)) && !a_bl[i][d];
      e_an[i]  = on ? ~(8'd1 << d) : 8'hFF;
      e_seg[i] = on ? {~a_dp[i][d], HEX[a_val[i][d]]} : 8'hFF;
      bnd = (c == 15) && (d == 0);
      e_fd[i] = bnd;
      for (int k = 0; k < nd[i]; k++) begin
        if (bnd && st_load) begin
          a_val[i][k] = st_val[4*k +: 4]; a_dp[i][k] = st_dp[k]; a_bl[i][k] = st_blank[k];
        end else if (bnd && pv[i]) begin
          a_val[i][k] = p_val[i][k]; a_dp[i][k] = p_dp[i][k]; a_bl[i][k] = p_bl[i][k];
        end else if (!bnd && st_load) begin
          p_val[i][k] = st_val[4*k +: 4]; p_dp[i][k] = st_dp[k]; p_bl[i][k] = st_blank[k];
        end
      end
      pv[i] = bnd ? 1'b0 : (pv[i] | st_load);
    end
    t++;
  endtask

  task automatic tick();
    model_step();
    @(posedge segclk);
    @(negedge segclk);
    chk("seg4", if4.seg, e_seg[0]);
    chk("an4", if4.an, e_an[0][3:0]);
    chk("fd4", if4.frame_done, e_fd[0]);
    chk("seg8", if8.seg, e_seg[1]);
    chk("an8", if8.an, e_an[1]);
    chk("fd8", if8.frame_done, e_fd[1]);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic load_frame(input logic [31:0] v, input logic [7:0] p, input logic [7:0] b);
    st_val = v; st_dp = p; st_blank = b; st_load = 1'b1;
    tick();
    st_load = 1'b0;
  endtask

  task automatic async_reset_check(input string tag);
    clr_n = 1'b0;
    #1;
    chk({tag, "_seg4"}, if4.seg, 32'hFF);
    chk({tag, "_an4"}, if4.an, 32'hF);
    chk({tag, "_seg8"}, if8.seg, 32'hFF);
    chk({tag, "_an8"}, if8.an, 32'hFF);
  endtask

  initial begin
    st_val = '0; st_dp = '0; st_blank = '1; st_load = 1'b0; st_bright = 4'd15;
    model_reset();
    #1;
    async_reset_check("rst_init");
    chk("rst_fd4", if4.frame_done, 32'h0);
    @(negedge segclk);
    run(3);
    clr_n = 1'b1;

    // No frame loaded: every digit stays dark regardless of brightness.
    for (int i = 0; i < 150; i++) begin
      st_bright = 4'($urandom_range(0, 15));
      tick();
    end

    st_bright = 4'd15;
    load_frame(32'h5678_1234, 8'h00, 8'h00);
    run(300);

    // Mid-frame load must not show until the next boundary.
    while (t % 128 != 40) tick();
    load_frame(32'h8888_8888, 8'h00, 8'h00);
    run(300);

    // Load exactly on the boundary cycle takes effect without a pending frame.
    while (t % 128 != 127) tick();
    load_frame(32'h0000_FEDC, 8'h00, 8'h00);
    run(100);

    st_bright = 4'd0;
    run(200);
    st_bright = 4'd7;
    run(200);

    st_bright = 4'd15;
    load_frame(32'h0000_1234, 8'b0000_1000, 8'b0000_0101);
    run(200);

    // Reset in the middle of a slot.
    while (t % 16 != 7) tick();
    async_reset_check("rst_mid");
    run(2);
    clr_n = 1'b1;
    run(100);

    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        st_val   = $urandom;
        st_dp    = 8'($urandom);
        st_blank = 8'($urandom) & 8'($urandom);
        st_load  = 1'b1;
      end else begin
        st_load = 1'b0;
      end
      if ($urandom_range(0, 9) == 0) st_bright = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 699) == 0) begin
        st_load = 1'b0;
        async_reset_check("rst_rand");
        run(1);
        clr_n = 1'b1;
      end
      tick();
    end
    st_load = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
